// File: rtl/trap_controller_if.sv
// Pipeline <-> trap controller bundle: trap requests and CSR strobes in, flush/redirect and CSR state out.
interface trap_controller_if #(
  parameter int unsigned XLEN = 32
);
  logic            exc_valid;
  logic [XLEN-1:0] exc_cause;
  logic [XLEN-1:0] exc_pc;
  logic            mret;
  logic            bnd_valid;
  logic [XLEN-1:0] bnd_pc;
  logic            irq_meip;
  logic            irq_msip;
  logic            irq_mtip;
  logic [2:0]      mie_en;
  logic [XLEN-1:0] mtvec_base;
  logic [1:0]      mtvec_mode;
  logic            mstatus_mie_we;
  logic            mstatus_mie_wd;
  logic            mstatus_mie;
  logic            mstatus_mpie;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] mcause;
  logic            flush;
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            busy;

  modport master (
    output exc_valid, exc_cause, exc_pc, mret, bnd_valid, bnd_pc,
           irq_meip, irq_msip, irq_mtip, mie_en, mtvec_base, mtvec_mode,
           mstatus_mie_we, mstatus_mie_wd,
    input  mstatus_mie, mstatus_mpie, mepc, mcause, flush, stall,
           redirect_valid, redirect_pc, busy
  );

  modport slave (
    input  exc_valid, exc_cause, exc_pc, mret, bnd_valid, bnd_pc,
           irq_meip, irq_msip, irq_mtip, mie_en, mtvec_base, mtvec_mode,
           mstatus_mie_we, mstatus_mie_wd,
    output mstatus_mie, mstatus_mpie, mepc, mcause, flush, stall,
           redirect_valid, redirect_pc, busy
  );
endinterface

// File: rtl/trap_controller.sv
// Machine-mode trap sequencer: arbitrates exceptions, interrupts and mret, drains the pipe, redirects fetch.
// Optional edge-triggered NMI input enabled by defining TRAP_NMI_EN.
module trap_controller #(
  parameter int unsigned     XLEN         = 32,
  parameter int unsigned     DRAIN_CYCLES = 2,
  parameter logic [XLEN-1:0] NMI_VECTOR   = XLEN'(32'h0000_0100)
) (
  input logic clk,
  input logic rst,
`ifdef TRAP_NMI_EN
  input logic nmi,
`endif
  trap_controller_if.slave bus
);

  localparam int unsigned CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1, REDIRECT = 2'd2} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            mie_q, mpie_q, flush_q, stall_q, rv_q, busy_q;
  logic [XLEN-1:0] mepc_q, mcause_q, rpc_q, target_q;

  logic            idle, take_nmi, take_exc, take_irq, take_mret, accept;
  logic [2:0]      irq_act;
  logic [3:0]      irq_code;
  logic [XLEN-1:0] base, trap_mepc, trap_cause, trap_target;

`ifdef TRAP_NMI_EN
  logic nmi_q, nmi_pending;

  // Rising edges collapse into a single pending NMI until it is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      nmi_q       <= 1'b0;
      nmi_pending <= 1'b0;
    end else begin
      nmi_q       <= nmi;
      nmi_pending <= (nmi_pending & ~take_nmi) | (nmi & ~nmi_q);
    end
  end

  assign take_nmi = idle & nmi_pending;
`else
  logic unused_nmi_vector;
  assign unused_nmi_vector = ^NMI_VECTOR;
  assign take_nmi = 1'b0;
`endif

  // Request arbitration and trap payload; only IDLE may accept.
  always_comb begin
    idle        = (state == IDLE);
    base        = bus.mtvec_base & ~XLEN'(3);
    irq_act     = {bus.irq_meip & bus.mie_en[2],
                   bus.irq_msip & bus.mie_en[0],
                   bus.irq_mtip & bus.mie_en[1]};
    irq_code    = irq_act[2] ? 4'd11 : (irq_act[1] ? 4'd3 : 4'd7);
    take_exc    = idle & ~take_nmi & bus.exc_valid;
    take_irq    = idle & ~take_nmi & ~bus.exc_valid & mie_q & bus.bnd_valid & (|irq_act);
    take_mret   = idle & ~take_nmi & ~bus.exc_valid & ~take_irq & bus.mret;
    accept      = take_nmi | take_exc | take_irq | take_mret;
    trap_mepc   = bus.exc_pc;
    trap_cause  = bus.exc_cause;
    trap_target = base;
`ifdef TRAP_NMI_EN
    if (take_nmi) begin
      trap_mepc   = bus.bnd_valid ? bus.bnd_pc : bus.exc_pc;
      trap_cause  = '0;
      trap_target = NMI_VECTOR;
    end else
`endif
    if (take_irq) begin
      trap_mepc  = bus.bnd_pc;
      trap_cause = {1'b1, (XLEN-1)'(irq_code)};
      if (bus.mtvec_mode == 2'd1) trap_target = base + XLEN'({irq_code, 2'b00});
    end else if (take_mret) begin
      trap_target = mepc_q;
    end
    trap_mepc = trap_mepc & ~XLEN'(3);
  end

  // CSR updates plus the drain/redirect sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      mie_q    <= 1'b0;
      mpie_q   <= 1'b0;
      flush_q  <= 1'b0;
      stall_q  <= 1'b0;
      rv_q     <= 1'b0;
      busy_q   <= 1'b0;
      mepc_q   <= '0;
      mcause_q <= '0;
      rpc_q    <= '0;
      target_q <= '0;
    end else begin
      if (accept) begin
        if (take_mret) begin
          mie_q  <= mpie_q;
          mpie_q <= 1'b1;
        end else begin
          mepc_q   <= trap_mepc;
          mcause_q <= trap_cause;
          mie_q    <= 1'b0;
          if (!take_nmi) mpie_q <= mie_q;
        end
      end else if (bus.mstatus_mie_we) begin
        mie_q <= bus.mstatus_mie_wd;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            state    <= DRAIN;
            cnt      <= CW'(DRAIN_CYCLES - 1);
            target_q <= trap_target;
            flush_q  <= 1'b1;
            stall_q  <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        DRAIN: begin
          if (cnt == '0) begin
            state   <= REDIRECT;
            stall_q <= 1'b0;
            rv_q    <= 1'b1;
            rpc_q   <= target_q;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        REDIRECT: begin
          state   <= IDLE;
          flush_q <= 1'b0;
          rv_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          flush_q <= 1'b0;
          stall_q <= 1'b0;
          rv_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mstatus_mie    = mie_q;
  assign bus.mstatus_mpie   = mpie_q;
  assign bus.mepc           = mepc_q;
  assign bus.mcause         = mcause_q;
  assign bus.flush          = flush_q;
  assign bus.stall          = stall_q;
  assign bus.redirect_valid = rv_q;
  assign bus.redirect_pc    = rpc_q;
  assign bus.busy           = busy_q;

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller (default build, DRAIN_CYCLES=2): traps, mret, masking, drain and reset.
module tb_trap_controller;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  trap_controller_if #(.XLEN(32)) bus ();

  trap_controller #(.XLEN(32), .DRAIN_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sw_mie(input logic v);
    bus.mstatus_mie_we = 1'b1;
    bus.mstatus_mie_wd = v;
    step();
    bus.mstatus_mie_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({bus.mstatus_mie, bus.mstatus_mpie, bus.flush, bus.stall, bus.redirect_valid, bus.busy} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b want 000000",
               {bus.mstatus_mie, bus.mstatus_mpie, bus.flush, bus.stall, bus.redirect_valid, bus.busy});
    end
    checks++;
    if ({bus.mepc, bus.mcause, bus.redirect_pc} !== 96'h0) begin
      failures++;
      $display("FAIL reset_regs: got %h want 0", {bus.mepc, bus.mcause, bus.redirect_pc});
    end
    rst = 1'b0;
  endtask

  task automatic test_exception();
    logic [3:0] exp;
    sw_mie(1'b1);
    checks++;
    if (bus.mstatus_mie !== 1'b1) begin
      failures++;
      $display("FAIL sw_mie_set: got %b want 1", bus.mstatus_mie);
    end
    bus.exc_valid  = 1'b1;
    bus.exc_cause  = 32'd2;
    bus.exc_pc     = 32'h80;
    bus.mtvec_base = 32'h1000;
    bus.mtvec_mode = 2'd0;
    step();
    bus.exc_valid = 1'b0;
    checks++;
    if ({bus.mepc, bus.mcause} !== {32'h80, 32'd2}) begin
      failures++;
      $display("FAIL exc_csr: got mepc=%h mcause=%h want 80/2", bus.mepc, bus.mcause);
    end
    checks++;
    if ({bus.mstatus_mie, bus.mstatus_mpie} !== 2'b01) begin
      failures++;
      $display("FAIL exc_mie_mpie: got %b want 01", {bus.mstatus_mie, bus.mstatus_mpie});
    end
    // {flush,stall,redirect_valid,busy} over the four cycles after acceptance
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) step();
      case (c)
        1, 2: exp = 4'b1101;
        3:    exp = 4'b1011;
        default: exp = 4'b0000;
      endcase
      checks++;
      if ({bus.flush, bus.stall, bus.redirect_valid, bus.busy} !== exp) begin
        failures++;
        $display("FAIL exc_seq_c%0d: got %b want %b", c,
                 {bus.flush, bus.stall, bus.redirect_valid, bus.busy}, exp);
      end
      if (c == 3) begin
        checks++;
        if (bus.redirect_pc !== 32'h1000) begin
          failures++;
          $display("FAIL exc_target: got %h want 00001000", bus.redirect_pc);
        end
      end
    end
  endtask

  task automatic test_vectored_mti();
    sw_mie(1'b1);
    bus.mie_en     = 3'b010;
    bus.irq_mtip   = 1'b1;
    bus.bnd_valid  = 1'b1;
    bus.bnd_pc     = 32'h200;
    bus.mtvec_mode = 2'd1;
    bus.mtvec_base = 32'h1000;
    step();
    bus.irq_mtip  = 1'b0;
    bus.bnd_valid = 1'b0;
    checks++;
    if ({bus.mcause, bus.mepc} !== {32'h8000_0007, 32'h200}) begin
      failures++;
      $display("FAIL mti_csr: got mcause=%h mepc=%h want 80000007/200", bus.mcause, bus.mepc);
    end
    checks++;
    if ({bus.mstatus_mie, bus.mstatus_mpie} !== 2'b01) begin
      failures++;
      $display("FAIL mti_mie_mpie: got %b want 01", {bus.mstatus_mie, bus.mstatus_mpie});
    end
    step();
    step();
    checks++;
    if ({bus.redirect_valid, bus.redirect_pc} !== {1'b1, 32'h101C}) begin
      failures++;
      $display("FAIL mti_target: got rv=%b pc=%h want 1/0000101c", bus.redirect_valid, bus.redirect_pc);
    end
    step();
  endtask

  task automatic test_mret();
    bus.mret = 1'b1;
    step();
    bus.mret = 1'b0;
    checks++;
    if ({bus.mstatus_mie, bus.mstatus_mpie} !== 2'b11) begin
      failures++;
      $display("FAIL mret_mie_mpie: got %b want 11", {bus.mstatus_mie, bus.mstatus_mpie});
    end
    checks++;
    if (bus.mcause !== 32'h8000_0007) begin
      failures++;
      $display("FAIL mret_mcause_kept: got %h want 80000007", bus.mcause);
    end
    step();
    step();
    checks++;
    if ({bus.redirect_valid, bus.redirect_pc} !== {1'b1, 32'h200}) begin
      failures++;
      $display("FAIL mret_target: got rv=%b pc=%h want 1/00000200", bus.redirect_valid, bus.redirect_pc);
    end
    step();
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL mret_idle: got busy=%b want 0", bus.busy);
    end
  endtask

  task automatic test_masked_priority();
    logic seen;
    sw_mie(1'b0);
    bus.irq_meip  = 1'b1;
    bus.irq_mtip  = 1'b1;
    bus.mie_en    = 3'b111;
    bus.bnd_valid = 1'b1;
    bus.bnd_pc    = 32'h300;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      seen |= bus.busy | bus.flush;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL masked_no_trap: got activity=%b want 0", seen);
    end
    sw_mie(1'b1);
    step();
    bus.irq_meip = 1'b0;
    bus.irq_mtip = 1'b0;
    checks++;
    if ({bus.mcause, bus.mepc} !== {32'h8000_000B, 32'h300}) begin
      failures++;
      $display("FAIL mei_csr: got mcause=%h mepc=%h want 8000000b/300", bus.mcause, bus.mepc);
    end
    step();
    step();
    checks++;
    if ({bus.redirect_valid, bus.redirect_pc} !== {1'b1, 32'h102C}) begin
      failures++;
      $display("FAIL mei_target: got rv=%b pc=%h want 1/0000102c", bus.redirect_valid, bus.redirect_pc);
    end
    step();
    // Exception and interrupt in the same cycle: exception, base target, aligned mepc
    sw_mie(1'b1);
    bus.irq_meip  = 1'b1;
    bus.exc_valid = 1'b1;
    bus.exc_cause = 32'd5;
    bus.exc_pc    = 32'h406;
    step();
    bus.irq_meip  = 1'b0;
    bus.exc_valid = 1'b0;
    checks++;
    if ({bus.mcause, bus.mepc} !== {32'd5, 32'h404}) begin
      failures++;
      $display("FAIL exc_over_irq: got mcause=%h mepc=%h want 5/404", bus.mcause, bus.mepc);
    end
    step();
    step();
    checks++;
    if ({bus.redirect_valid, bus.redirect_pc} !== {1'b1, 32'h1000}) begin
      failures++;
      $display("FAIL exc_no_vector: got rv=%b pc=%h want 1/00001000", bus.redirect_valid, bus.redirect_pc);
    end
    step();
    // Enabled interrupt but no interruptible instruction at the boundary
    sw_mie(1'b1);
    bus.irq_mtip  = 1'b1;
    bus.mie_en    = 3'b010;
    bus.bnd_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      seen |= bus.busy | bus.flush;
    end
    bus.irq_mtip = 1'b0;
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL no_bnd_no_trap: got activity=%b want 0", seen);
    end
  endtask

  task automatic test_drain_immunity();
    int rcount;
    sw_mie(1'b0);
    bus.exc_valid = 1'b1;
    bus.exc_cause = 32'd4;
    bus.exc_pc    = 32'h500;
    step();
    bus.exc_cause = 32'd6;
    bus.exc_pc    = 32'h600;
    bus.mret      = 1'b1;
    bus.mstatus_mie_we = 1'b1;
    bus.mstatus_mie_wd = 1'b1;
    step();
    bus.exc_valid = 1'b0;
    bus.mret      = 1'b0;
    bus.mstatus_mie_we = 1'b0;
    rcount = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.redirect_valid === 1'b1) rcount++;
      step();
    end
    checks++;
    if (rcount !== 1) begin
      failures++;
      $display("FAIL drain_one_redirect: got %0d want 1", rcount);
    end
    checks++;
    if ({bus.mepc, bus.mcause} !== {32'h500, 32'd4}) begin
      failures++;
      $display("FAIL drain_csr_kept: got mepc=%h mcause=%h want 500/4", bus.mepc, bus.mcause);
    end
    checks++;
    if (bus.mstatus_mie !== 1'b1) begin
      failures++;
      $display("FAIL drain_sw_write: got %b want 1", bus.mstatus_mie);
    end
  endtask

  task automatic test_reset_mid_drain();
    bus.exc_valid = 1'b1;
    bus.exc_cause = 32'd3;
    bus.exc_pc    = 32'h700;
    step();
    bus.exc_valid = 1'b0;
    checks++;
    if ({bus.flush, bus.stall} !== 2'b11) begin
      failures++;
      $display("FAIL pre_reset_drain: got %b want 11", {bus.flush, bus.stall});
    end
    rst = 1'b1;
    step();
    checks++;
    if ({bus.mstatus_mie, bus.mstatus_mpie, bus.flush, bus.stall, bus.redirect_valid, bus.busy} !== 6'b0) begin
      failures++;
      $display("FAIL rst_drain_flags: got %b want 000000",
               {bus.mstatus_mie, bus.mstatus_mpie, bus.flush, bus.stall, bus.redirect_valid, bus.busy});
    end
    checks++;
    if ({bus.mepc, bus.mcause} !== 64'h0) begin
      failures++;
      $display("FAIL rst_drain_csr: got mepc=%h mcause=%h want 0/0", bus.mepc, bus.mcause);
    end
    rst = 1'b0;
    step();
    step();
    checks++;
    if ({bus.flush, bus.redirect_valid, bus.busy} !== 3'b000) begin
      failures++;
      $display("FAIL rst_drain_idle: got %b want 000", {bus.flush, bus.redirect_valid, bus.busy});
    end
  endtask

  initial begin
    rst                = 1'b1;
    bus.exc_valid      = 1'b0;
    bus.exc_cause      = '0;
    bus.exc_pc         = '0;
    bus.mret           = 1'b0;
    bus.bnd_valid      = 1'b0;
    bus.bnd_pc         = '0;
    bus.irq_meip       = 1'b0;
    bus.irq_msip       = 1'b0;
    bus.irq_mtip       = 1'b0;
    bus.mie_en         = 3'b000;
    bus.mtvec_base     = '0;
    bus.mtvec_mode     = 2'd0;
    bus.mstatus_mie_we = 1'b0;
    bus.mstatus_mie_wd = 1'b0;
    test_reset();
    test_exception();
    test_vectored_mti();
    test_mret();
    test_masked_priority();
    test_drain_immunity();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
